// File: rtl/prog_seq_ctrl_if.sv
// Program-counter / ROM bus between the sequencer (master) and the up-down
// program counter plus combinational program ROM (slave).
interface prog_seq_ctrl_if #(
  parameter int DW  = 4,
  parameter int OPW = 4
);
  logic [OPW+DW-1:0] instr;
  logic              pc_ovf;
  logic              pc_en;
  logic              pc_ld;
  logic              pc_dir;
  logic [DW-1:0]     pc_in;
  logic              pc_clr;

  modport master (
    input  instr,
    input  pc_ovf,
    output pc_en,
    output pc_ld,
    output pc_dir,
    output pc_in,
    output pc_clr
  );

  modport slave (
    output instr,
    output pc_ovf,
    input  pc_en,
    input  pc_ld,
    input  pc_dir,
    input  pc_in,
    input  pc_clr
  );
endinterface

// File: rtl/prog_seq_ctrl.sv
// Two-cycle FETCH/EXEC sequencer for a small ADD/JMP instruction set; drives the
// external program counter and presents accumulator results to the display stage.
module prog_seq_ctrl #(
  parameter int DW  = 4,
  parameter int OPW = 4
) (
  input  logic            c,
  input  logic            clr,
  input  logic            run,
  prog_seq_ctrl_if.master pcb,
  output logic [DW-1:0]   acc,
  output logic            cy,
  output logic            zf,
  output logic [DW-1:0]   out_data,
  output logic            out_vld,
  output logic            halted,
  output logic            wrapped
);

  localparam int IW = OPW + DW;

  localparam logic [OPW-1:0] OP_NOP = OPW'(0);
  localparam logic [OPW-1:0] OP_LDI = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_JMP = OPW'(3);
  localparam logic [OPW-1:0] OP_JC  = OPW'(4);
  localparam logic [OPW-1:0] OP_JZ  = OPW'(5);
  localparam logic [OPW-1:0] OP_OUT = OPW'(6);
  localparam logic [OPW-1:0] OP_HLT = {OPW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   ir_reg, ir_next;
  logic [DW-1:0]   acc_reg, acc_next;
  logic            cy_reg, cy_next;
  logic            zf_reg, zf_next;
  logic [DW-1:0]   out_data_reg, out_data_next;
  logic            out_vld_reg, out_vld_next;
  logic            wrapped_reg, wrapped_next;

  logic            step_en;
  logic            jump_ld;
  logic            hold_clr;

  logic [OPW-1:0]  op;
  logic [DW-1:0]   k;
  logic [DW:0]     add_sum;

  assign op      = ir_reg[IW-1:DW];
  assign k       = ir_reg[DW-1:0];
  assign add_sum = {1'b0, acc_reg} + {1'b0, k};

  always_ff @(posedge c) begin
    if (clr) begin
      state_reg    <= S_IDLE;
      ir_reg       <= '0;
      acc_reg      <= '0;
      cy_reg       <= 1'b0;
      zf_reg       <= 1'b0;
      out_data_reg <= '0;
      out_vld_reg  <= 1'b0;
      wrapped_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ir_reg       <= ir_next;
      acc_reg      <= acc_next;
      cy_reg       <= cy_next;
      zf_reg       <= zf_next;
      out_data_reg <= out_data_next;
      out_vld_reg  <= out_vld_next;
      wrapped_reg  <= wrapped_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    ir_next       = ir_reg;
    acc_next      = acc_reg;
    cy_next       = cy_reg;
    zf_next       = zf_reg;
    out_data_next = out_data_reg;
    out_vld_next  = 1'b0;
    step_en       = 1'b0;
    jump_ld       = 1'b0;
    hold_clr      = 1'b0;

    unique case (state_reg)
      S_IDLE: begin
        hold_clr = !run;
        if (run) begin
          state_next = S_FETCH;
        end
      end

      S_FETCH: begin
        ir_next    = pcb.instr;
        state_next = S_EXEC;
      end

      S_EXEC: begin
        state_next = S_FETCH;
        step_en    = 1'b1;
        // zf only moves when acc is written, so JZ sees the flag of the last LDI/ADD
        unique case (op)
          OP_LDI: begin
            acc_next = k;
            zf_next  = (k == '0);
          end
          OP_ADD: begin
            {cy_next, acc_next} = add_sum;
            zf_next             = (add_sum[DW-1:0] == '0);
          end
          OP_JMP: begin
            step_en = 1'b0;
            jump_ld = 1'b1;
          end
          OP_JC: begin
            step_en = !cy_reg;
            jump_ld = cy_reg;
          end
          OP_JZ: begin
            step_en = !zf_reg;
            jump_ld = zf_reg;
          end
          OP_OUT: begin
            out_data_next = acc_reg;
            out_vld_next  = 1'b1;
          end
          OP_HLT: begin
            step_en    = 1'b0;
            state_next = S_HALT;
          end
          OP_NOP:  ;
          default: ;
        endcase
      end

      S_HALT: ;

      default: state_next = S_IDLE;
    endcase

    // Only a sequential step past the top address counts as a wrap, never a load
    wrapped_next = wrapped_reg | (step_en & pcb.pc_ovf);
  end

  assign pcb.pc_en  = step_en;
  assign pcb.pc_ld  = jump_ld;
  assign pcb.pc_dir = 1'b0;
  assign pcb.pc_in  = k;
  assign pcb.pc_clr = hold_clr;

  assign acc      = acc_reg;
  assign cy       = cy_reg;
  assign zf       = zf_reg;
  assign out_data = out_data_reg;
  assign out_vld  = out_vld_reg;
  assign halted   = (state_reg == S_HALT);
  assign wrapped  = wrapped_reg;

endmodule

// File: tb/tb_prog_seq_ctrl.sv
// Drives prog_seq_ctrl with a modelled up-counter and ROM, and compares it against
// an instruction-level model run over directed and random programs.
module tb_prog_seq_ctrl;
  localparam int DW  = 4;
  localparam int OPW = 4;
  localparam int IW  = OPW + DW;

  logic          c = 1'b0;
  logic          clr;
  logic          run;
  logic [DW-1:0] acc;
  logic          cy;
  logic          zf;
  logic [DW-1:0] out_data;
  logic          out_vld;
  logic          halted;
  logic          wrapped;

  prog_seq_ctrl_if #(.DW(DW), .OPW(OPW)) pcb ();

  prog_seq_ctrl #(.DW(DW), .OPW(OPW)) dut (
    .c        (c),
    .clr      (clr),
    .run      (run),
    .pcb      (pcb.master),
    .acc      (acc),
    .cy       (cy),
    .zf       (zf),
    .out_data (out_data),
    .out_vld  (out_vld),
    .halted   (halted),
    .wrapped  (wrapped)
  );

  always #5 c = ~c;

  // Environment: 16-word ROM and up-down counter (counter also cleared by clr)
  logic [IW-1:0] rom [16];
  logic [DW-1:0] pc;

  assign pcb.instr  = rom[pc];
  assign pcb.pc_ovf = (pc == 4'd15);

  always @(posedge c) begin
    if (clr || pcb.pc_clr)  pc <= '0;
    else if (pcb.pc_ld)     pc <= pcb.pc_in;
    else if (pcb.pc_en)     pc <= pcb.pc_dir ? pc - 4'd1 : pc + 4'd1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 16; a++) rom[a] = 8'hF0;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_acc"},     acc, 0);
    check_eq({tag, "_cy"},      cy, 0);
    check_eq({tag, "_zf"},      zf, 0);
    check_eq({tag, "_outd"},    out_data, 0);
    check_eq({tag, "_outv"},    out_vld, 0);
    check_eq({tag, "_halted"},  halted, 0);
    check_eq({tag, "_wrapped"}, wrapped, 0);
    check_eq({tag, "_pc_en"},   pcb.pc_en, 0);
    check_eq({tag, "_pc_ld"},   pcb.pc_ld, 0);
    check_eq({tag, "_pc_in"},   pcb.pc_in, 0);
    check_eq({tag, "_pc_dir"},  pcb.pc_dir, 0);
    check_eq({tag, "_pc_clr"},  pcb.pc_clr, 1);
    check_eq({tag, "_pc"},      pc, 0);
  endtask

  task automatic do_reset(input int n_idle);
    @(negedge c);
    clr = 1'b1;
    run = 1'b0;
    repeat (2) @(negedge c);
    clr = 1'b0;
    #1 check_quiet("rst");
    for (int i = 0; i < n_idle; i++) begin
      @(negedge c);
      check_quiet("idle");
    end
  endtask

  // Instruction-level reference: one loop iteration per instruction, 2 clocks each
  task automatic run_prog(input string name, input int max_instr, input int clr_at);
    logic [DW-1:0] m_pc, m_acc, m_out, k;
    logic          m_cy, m_zf, m_wr, pend, e_en, e_ld;
    int            op, sum, n_out, n_seen;
    bit            done;
    m_pc = '0; m_acc = '0; m_out = '0;
    m_cy = 1'b0; m_zf = 1'b0; m_wr = 1'b0; pend = 1'b0;
    n_out = 0; n_seen = 0; done = 0;

    do_reset(1);
    run = 1'b1;
    #1 check_eq("run_pc_clr", pcb.pc_clr, 0);

    for (int i = 0; i < max_instr && !done; i++) begin
      @(negedge c);  // FETCH
      check_eq("f_pc",      pc, m_pc);
      check_eq("f_halted",  halted, 0);
      check_eq("f_acc",     acc, m_acc);
      check_eq("f_cy",      cy, m_cy);
      check_eq("f_zf",      zf, m_zf);
      check_eq("f_wrapped", wrapped, m_wr);
      check_eq("f_out_vld", out_vld, pend);
      check_eq("f_out_data", out_data, m_out);
      check_eq("f_strobes", {pcb.pc_en, pcb.pc_ld, pcb.pc_clr}, 0);
      if (out_vld === 1'b1) n_seen++;
      pend = 1'b0;
      run  = 1'($urandom);

      @(negedge c);  // EXEC
      op = int'(rom[m_pc][7:4]);
      k  = rom[m_pc][3:0];
      e_ld = (op == 3) || (op == 4 && m_cy) || (op == 5 && m_zf);
      e_en = !e_ld && (op != 15);
      $display("%s #%0d pc=%0d op=%0h k=%0h acc=%0h cy=%0b zf=%0b en=%0b ld=%0b",
               name, i, m_pc, op, k, m_acc, m_cy, m_zf, e_en, e_ld);
      check_eq("x_pc_en",  pcb.pc_en, e_en);
      check_eq("x_pc_ld",  pcb.pc_ld, e_ld);
      check_eq("x_excl",   pcb.pc_en & pcb.pc_ld, 0);
      check_eq("x_pc_dir", pcb.pc_dir, 0);
      check_eq("x_pc_clr", pcb.pc_clr, 0);
      check_eq("x_pc_in",  pcb.pc_in, k);
      check_eq("x_out_vld", out_vld, 0);
      check_eq("x_halted", halted, 0);

      if (i == clr_at) begin
        clr = 1'b1;
        run = 1'b0;
        @(negedge c);
        clr = 1'b0;
        #1 check_quiet("midclr");
        return;
      end

      case (op)
        1: begin m_acc = k; m_zf = (k == 0); end
        2: begin
          sum   = int'(m_acc) + int'(k);
          m_cy  = (sum > 15);
          m_acc = 4'(sum % 16);
          m_zf  = (m_acc == 0);
        end
        6: begin pend = 1'b1; m_out = m_acc; n_out++; end
        15: done = 1;
        default: ;
      endcase
      if (e_en && m_pc == 4'd15) m_wr = 1'b1;
      if (e_ld)      m_pc = k;
      else if (e_en) m_pc = m_pc + 4'd1;
    end

    if (done) begin
      for (int h = 0; h < 4; h++) begin
        @(negedge c);
        check_eq("h_halted",  halted, 1);
        check_eq("h_pc",      pc, m_pc);
        check_eq("h_acc",     acc, m_acc);
        check_eq("h_cy",      cy, m_cy);
        check_eq("h_zf",      zf, m_zf);
        check_eq("h_wrapped", wrapped, m_wr);
        check_eq("h_out_vld", out_vld, 0);
        check_eq("h_out_data", out_data, m_out);
        check_eq("h_strobes", {pcb.pc_en, pcb.pc_ld, pcb.pc_clr}, 0);
        run = 1'($urandom);
      end
      check_eq("out_count", n_seen, n_out);
      $display("%s halted pc=%0d acc=%0h cy=%0b outs=%0d", name, m_pc, m_acc, m_cy, n_out);
    end
  endtask

  initial begin
    clr = 1'b1;
    run = 1'b0;
    clear_rom();
    do_reset(10);

    // LDI 9; ADD 8; OUT; HLT -> acc=1, cy=1, one OUT of 1
    clear_rom();
    rom[0] = 8'h19; rom[1] = 8'h28; rom[2] = 8'h60; rom[3] = 8'hF0;
    run_prog("addcy", 20, -1);
    check_eq("addcy_acc", acc, 1);
    check_eq("addcy_cy",  cy, 1);
    check_eq("addcy_out", out_data, 1);

    // LDI 0; JZ 4; OUT; HLT; LDI 5; OUT; HLT
    clear_rom();
    rom[0] = 8'h10; rom[1] = 8'h54; rom[2] = 8'h60; rom[3] = 8'hF0;
    rom[4] = 8'h15; rom[5] = 8'h60; rom[6] = 8'hF0;
    run_prog("jumps", 20, -1);
    check_eq("jumps_out", out_data, 5);

    // LDI 1; ADD 1; JC 0; HLT
    clear_rom();
    rom[0] = 8'h11; rom[1] = 8'h21; rom[2] = 8'h40; rom[3] = 8'hF0;
    run_prog("jcnt", 20, -1);
    check_eq("jcnt_cy", cy, 0);
    check_eq("jcnt_pc", pc, 3);

    // 16 NOPs: wraps from 15 to 0 and keeps running
    for (int a = 0; a < 16; a++) rom[a] = 8'h00;
    run_prog("wrap", 20, -1);
    check_eq("wrap_flag", wrapped, 1);

    // clr during EXEC of ADD
    clear_rom();
    rom[0] = 8'h19; rom[1] = 8'h28; rom[2] = 8'h60; rom[3] = 8'hF0;
    run_prog("midclr", 20, 1);

    for (int r = 0; r < 30; r++) begin
      for (int a = 0; a < 16; a++) rom[a] = IW'($urandom);
      run_prog($sformatf("rnd%0d", r), int'($urandom_range(5, 30)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_seq_ctrl.md
# prog_seq_ctrl

Instruction sequencer that drives the up-down program counter: it sets the counter's `en`, `ld`, `dir`, `in` and `clr` inputs, and consumes the counter's `ovf`. It also reads instructions from the combinational program ROM, which is addressed by the counter's `out`. The block executes a small ADD/JMP instruction set on an internal accumulator and presents results to the downstream display-register stage.

## Interface
- `DW`, default 4: data/operand width; equals the program counter `bits`.
- `OPW`, default 4: opcode width; instruction width is `OPW+DW`.
- `c` input 1: clock; all state updates on its rising edge.
- `clr` input 1: reset, synchronous, active-high.
- `run` input 1: start request, sampled in IDLE; level-sensitive.
- `instr` input `OPW+DW`: ROM word at the current PC; valid combinationally.
- `pc_ovf` input 1: program counter overflow flag.
- `pc_en` output 1: counter enable, one-cycle pulse per sequential step.
- `pc_ld` output 1: counter load, one-cycle pulse on a taken jump.
- `pc_dir` output 1: counter direction; tied 0 (count up).
- `pc_in` output `DW`: jump target; equals the IR operand.
- `pc_clr` output 1: counter clear.
- `acc` output `DW`: accumulator.
- `cy` output 1: carry flag.
- `zf` output 1: zero flag, `acc==0`, registered with `acc`.
- `out_data` output `DW`: last OUT value.
- `out_vld` output 1: one-cycle strobe with `out_data`.
- `halted` output 1: high in HALT.
- `wrapped` output 1: sticky; PC wrapped past its max address.

## Operation
- States: IDLE, FETCH, EXEC, HALT.
- Reset (`clr=1`) forces the following, taking priority over everything, at any state:
  - state to IDLE;
  - `acc`, `cy`, `zf`, `out_data`, `out_vld`, `wrapped`, `halted`, and the IR all to 0.
- IDLE with `run=0`:
  - all `pc_*` strobes are 0.
  - `pc_clr=1` to hold the PC at 0.
- IDLE with `run=1`: goes to FETCH next cycle; `pc_clr=0` from that cycle.
- FETCH: `IR <= instr`; goes to EXEC.
- EXEC decodes `IR[OPW+DW-1:DW]` with operand `k=IR[DW-1:0]`:
  - 0 NOP: `pc_en=1`.
  - 1 LDI: `acc<=k`, `cy` unchanged, `pc_en=1`.
  - 2 ADD: `{cy,acc} <= acc + k`, computed at `DW+1` bits; `acc` wraps modulo `2^DW`. `pc_en=1`.
  - 3 JMP: `pc_ld=1`, `pc_in=k`.
  - 4 JC: if `cy`, `pc_ld=1`; else `pc_en=1`.
  - 5 JZ: if `zf`, `pc_ld=1`; else `pc_en=1`.
  - 6 OUT: `out_data<=acc`, `out_vld=1` next cycle for exactly one cycle, `pc_en=1`.
  - F HLT: no PC strobe; go to HALT.
  - Any other opcode behaves as NOP.
- After EXEC (except HLT), the next state is FETCH.
- `pc_en` and `pc_ld` are never high together.
- Wrap: `wrapped<=1` when `pc_en=1` and `pc_ovf=1` in the same cycle. The PC itself wraps to 0 and execution continues. A `pc_ld` never sets `wrapped`.
- HALT:
  - `halted=1`; all strobes 0; `acc` and flags are held.
  - Exits only via `clr`; `run` is ignored.
- `zf` is registered from the next value of `acc`, so it is valid in the cycle after LDI/ADD. JZ tests that registered value.

## Timing
- 2 cycles per instruction (FETCH + EXEC). Throughput is one instruction per 2 clocks.
- PC strobes are combinational from state and IR, asserted during EXEC only. The counter updates on the EXEC→FETCH edge, and `instr` for the new PC is valid during that FETCH.
- `acc`, `cy`, `zf` update on the EXEC→FETCH edge.
- `out_vld` is registered: high in the FETCH cycle after an OUT EXEC.
- First FETCH occurs 1 cycle after `run` is seen high in IDLE, with PC=0.
- `clr` mid-EXEC suppresses that instruction's register effects. Strobes seen in that cycle are don't-care, because the counter is also cleared by the same `clr`.
- All outputs are 0 in the cycle after `clr`, except `pc_clr`, which is 1 (IDLE with `run=0`).

## Test plan
- Reset/idle: `clr` for 2 cycles, then `run=0` → `pc_clr=1`, all other outputs 0, and the PC stays 0 for 10 cycles.
- ADD carry: program LDI 9; ADD 8; OUT; HLT. Required response:
  - `acc=1`, `cy=1`;
  - `out_vld` pulses once with `out_data=1`;
  - `halted=1` at cycle 8 after start.
- Jumps: program LDI 0; JZ 4; OUT; HLT; LDI 5; OUT; HLT. Required response:
  - JZ asserts `pc_ld` with `pc_in=4`;
  - `out_data=5`; the OUT at address 2 never fires.
- JC not taken: program LDI 1; ADD 1; JC 0; HLT → `pc_en` at JC, `halted` at address 3, `cy=0`.
- Wrap: a 16-word ROM of NOPs with `DW=4` → `wrapped` sets on the step from PC=15 to 0; execution continues at address 0.
- Reset mid-run: assert `clr` during the EXEC of ADD → `acc=0`, state IDLE, no `out_vld`, `halted=0`.
